// File: rtl/mau_controller.sv
// mau_controller: host command sequencer for the cpu mau ports and the run/stop (alive) control.
// Optional feature macro MAU_WATCHDOG_EN bounds every run to WATCHDOG_CYCLES alive cycles.
module mau_controller #(
  parameter int unsigned READ_LATENCY    = 2,
  parameter int unsigned WATCHDOG_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_target,
  input  logic [31:0] cmd_address,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] mau_address_im,
  output logic [31:0] mau_address_dm,
  output logic [31:0] mau_address_rf,
  output logic [31:0] mau_write_data_im,
  output logic [31:0] mau_write_data_dm,
  output logic [31:0] mau_write_data_rf,
  output logic        mau_wren_im,
  output logic        mau_wren_dm,
  output logic        mau_wren_rf,
  input  logic [31:0] mau_read_data_im,
  input  logic [31:0] mau_read_data_dm,
  input  logic [31:0] mau_read_data_rf,
  output logic        alive,
  input  logic        halt,
  input  logic [6:0]  clk_sequence,
  output logic        running,
  output logic [31:0] cycle_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WRITE     = 3'd1;
  localparam logic [2:0] S_READ_WAIT = 3'd2;
  localparam logic [2:0] S_RUNNING   = 3'd3;
  localparam logic [2:0] S_STOPPING  = 3'd4;
  localparam logic [2:0] S_RESPOND   = 3'd5;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;

  localparam logic [1:0] T_IM  = 2'd0;
  localparam logic [1:0] T_DM  = 2'd1;
  localparam logic [1:0] T_RF  = 2'd2;
  localparam logic [1:0] T_BAD = 2'd3;
  localparam logic [1:0] OP_STOP = 2'd3;

  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  tgt_q, tgt_d;
  logic [2:0]  lat_q, lat_d;
  logic        alive_q, alive_d;
  logic [31:0] cc_q, cc_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] addr_im_q, addr_im_d, addr_dm_q, addr_dm_d, addr_rf_q, addr_rf_d;
  logic [31:0] wdata_im_q, wdata_im_d, wdata_dm_q, wdata_dm_d, wdata_rf_q, wdata_rf_d;
  logic        wren_im_q, wren_im_d, wren_dm_q, wren_dm_d, wren_rf_q, wren_rf_d;

  logic        cmd_fire;
  logic [31:0] cc_inc;
  logic [31:0] rd_mux;
  logic        unused_seq;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

`ifdef MAU_WATCHDOG_EN
  localparam logic [31:0] WD_LIMIT = 32'(WATCHDOG_CYCLES);
`else
  logic unused_wd;
  assign unused_wd = ^WATCHDOG_CYCLES;
`endif

  assign unused_seq = ^clk_sequence[5:0];

  assign cmd_ready = rst_n && ((state_q == S_IDLE) || (state_q == S_RUNNING));
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign cc_inc    = sat_inc(cc_q);

  always_comb begin
    case (tgt_q)
      T_IM:    rd_mux = mau_read_data_im;
      T_DM:    rd_mux = mau_read_data_dm;
      default: rd_mux = mau_read_data_rf;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    lat_d      = lat_q;
    alive_d    = alive_q;
    cc_d       = cc_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    addr_im_d  = addr_im_q;
    addr_dm_d  = addr_dm_q;
    addr_rf_d  = addr_rf_q;
    wdata_im_d = wdata_im_q;
    wdata_dm_d = wdata_dm_q;
    wdata_rf_d = wdata_rf_q;
    wren_im_d  = 1'b0;
    wren_dm_d  = 1'b0;
    wren_rf_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_WRITE, OP_READ: begin
              if (cmd_target == T_BAD) begin
                state_d    = S_RESPOND;
                rsp_data_d = '0;
                rsp_err_d  = 1'b1;
              end else begin
                tgt_d   = cmd_target;
                lat_d   = '0;
                state_d = (cmd_op == OP_WRITE) ? S_WRITE : S_READ_WAIT;
                // Address/data land on the port registers now, so wren is visible exactly one cycle later.
                case (cmd_target)
                  T_IM: begin
                    addr_im_d = cmd_address;
                    if (cmd_op == OP_WRITE) begin
                      wdata_im_d = cmd_data;
                      wren_im_d  = 1'b1;
                    end
                  end
                  T_DM: begin
                    addr_dm_d = cmd_address;
                    if (cmd_op == OP_WRITE) begin
                      wdata_dm_d = cmd_data;
                      wren_dm_d  = 1'b1;
                    end
                  end
                  T_RF: begin
                    addr_rf_d = cmd_address;
                    if (cmd_op == OP_WRITE) begin
                      wdata_rf_d = cmd_data;
                      wren_rf_d  = 1'b1;
                    end
                  end
                  default: ;
                endcase
              end
            end
            OP_RUN: begin
              cc_d    = '0;
              alive_d = 1'b1;
              state_d = S_RUNNING;
            end
            default: begin
              state_d    = S_RESPOND;
              rsp_data_d = '0;
              rsp_err_d  = 1'b1;
            end
          endcase
        end
      end
      S_WRITE: begin
        state_d    = S_RESPOND;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
      end
      S_READ_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d    = S_RESPOND;
          rsp_data_d = rd_mux;
          rsp_err_d  = 1'b0;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_RUNNING: begin
        cc_d = cc_inc;
        // Halt outranks a STOP accepted in the same cycle; other accepted commands are dropped.
        if (halt) begin
          alive_d    = 1'b0;
          rsp_data_d = cc_inc;
          rsp_err_d  = 1'b0;
          state_d    = S_RESPOND;
        end else if (cmd_fire && (cmd_op == OP_STOP)) begin
          state_d = S_STOPPING;
`ifdef MAU_WATCHDOG_EN
        end else if (cc_inc >= WD_LIMIT) begin
          if (clk_sequence[6]) begin
            alive_d    = 1'b0;
            rsp_data_d = cc_inc;
            rsp_err_d  = 1'b1;
            state_d    = S_RESPOND;
          end else begin
            state_d = S_STOPPING;
          end
`endif
        end
      end
      S_STOPPING: begin
        cc_d = cc_inc;
        // Keep alive until the PC-update phase so the in-flight instruction retires.
        if (halt || clk_sequence[6]) begin
          alive_d    = 1'b0;
          rsp_data_d = cc_inc;
          rsp_err_d  = !halt;
          state_d    = S_RESPOND;
        end
      end
      S_RESPOND: begin
        if (rsp_ready) begin
          state_d    = S_IDLE;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        alive_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tgt_q      <= '0;
      lat_q      <= '0;
      alive_q    <= 1'b0;
      cc_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      addr_im_q  <= '0;
      addr_dm_q  <= '0;
      addr_rf_q  <= '0;
      wdata_im_q <= '0;
      wdata_dm_q <= '0;
      wdata_rf_q <= '0;
      wren_im_q  <= 1'b0;
      wren_dm_q  <= 1'b0;
      wren_rf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      lat_q      <= lat_d;
      alive_q    <= alive_d;
      cc_q       <= cc_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      addr_im_q  <= addr_im_d;
      addr_dm_q  <= addr_dm_d;
      addr_rf_q  <= addr_rf_d;
      wdata_im_q <= wdata_im_d;
      wdata_dm_q <= wdata_dm_d;
      wdata_rf_q <= wdata_rf_d;
      wren_im_q  <= wren_im_d;
      wren_dm_q  <= wren_dm_d;
      wren_rf_q  <= wren_rf_d;
    end
  end

  assign rsp_valid         = (state_q == S_RESPOND);
  assign rsp_data          = rsp_data_q;
  assign rsp_err           = rsp_err_q;
  assign mau_address_im    = addr_im_q;
  assign mau_address_dm    = addr_dm_q;
  assign mau_address_rf    = addr_rf_q;
  assign mau_write_data_im = wdata_im_q;
  assign mau_write_data_dm = wdata_dm_q;
  assign mau_write_data_rf = wdata_rf_q;
  assign mau_wren_im       = wren_im_q && !alive_q;
  assign mau_wren_dm       = wren_dm_q && !alive_q;
  assign mau_wren_rf       = wren_rf_q && !alive_q;
  assign alive             = alive_q;
  assign running           = alive_q;
  assign cycle_count       = cc_q;

endmodule
